uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- 8N1 UART receive path, the counterpart of the existing UART transmitter on the same serial link to the host.
- Synchronises the asynchronous rx line and oversamples it at 16x baud. Decodes start/data/stop and presents each byte on a single-entry valid/ack output register to the command decoder.
- Reports framing errors and overruns as one-cycle pulses.

Parameters:
- CLK_HZ, 150000000, system clock frequency in Hz
- BAUD, 115200, line rate in bits/s
- ACC_W, 29, width of the fractional baud accumulator; must satisfy 2^ACC_W > CLK_HZ

Ports:
- sys_clk_i  input  1  system clock, 150 MHz
- sys_rst_i  input  1  reset, asynchronous, active-high
- uart_rx  input  1  serial line, idle high, asynchronous to sys_clk_i
- uart_dat_o  output  8  received byte, stable while uart_valid_o=1
- uart_valid_o  output  1  byte available
- uart_ack_i  input  1  consumer takes byte; meaningful only when uart_valid_o=1
- uart_frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- uart_overrun_o  output  1  one-cycle pulse: byte completed while the holding register was full

Behaviour:
- Reset (async assert, sync deassert to sys_clk_i):
  - uart_dat_o=0, uart_valid_o=0, both error pulses 0.
  - FSM=IDLE, accumulator=0.
  - Synchroniser flops reset to 1 (line idle).
- Synchroniser:
  - 2 flops on uart_rx; all logic uses the second-stage output rxs.
  - 2-cycle input latency.
- Tick generator:
  - acc += 16*BAUD each cycle; on acc >= CLK_HZ, acc -= CLK_HZ and tick=1 for one cycle.
  - Average tick rate is exactly 16*BAUD, 1843200 Hz at defaults (one tick per ~81.4 clocks).
  - Free-running; not restarted by start-bit detection. Resulting phase error is ≤1/16 bit.
- Sample counter:
  - scnt is 4 bits and advances on tick only.
  - Bit value is the majority of rxs at scnt=7,8,9 of each bit.
- FSM transitions, evaluated on tick only:
  - IDLE: rxs=0 -> START, scnt=0.
  - START: at scnt=9, voted bit=1 means false start -> IDLE. Otherwise continue; at scnt=15 -> DATA, bit index=0.
  - DATA: vote at scnt=9, shifted in LSB-first. At scnt=15, after bit 7 -> STOP, else bit index+1.
  - STOP: vote at scnt=9.
    - Voted 1 -> deliver byte, -> IDLE. The next start edge is accepted from stop-bit sample 10 onward, tolerating a short stop bit.
    - Voted 0 -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: stay until rxs=1 on a tick, then -> IDLE. Break conditions therefore produce exactly one frame_err.
- Delivery happens in the clock cycle after the STOP sample tick:
  - valid=0: dat<=byte, valid<=1.
  - valid=1 with ack=1 in the same cycle: dat<=new byte, valid stays 1, no overrun.
  - valid=1 with ack=0: old byte kept, new byte dropped, overrun pulse.
- ack with valid=1 and no delivery: valid<=0 next cycle; dat holds its value.
- ack with valid=0 is ignored.
- frame_err and overrun never assert in the same cycle.
- Reset mid-frame aborts the frame; no pulse and no delivery.
- Latency: valid rises 1 clock after the tick at stop-bit sample 9, about 9.5 bit times after the start edge plus 2-3 synchroniser cycles.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - OVERSAMPLE=16.
  - Sample-point constants 7/8/9.
  - Default CLK_HZ/BAUD, to be reused by the transmitter.
- Sub-module uart_baud_gen: fractional accumulator producing a tick at a parameterised rate, so the transmitter can later adopt it.
- Synchroniser, vote, FSM and output register stay inline.

Test Plan:
- Send 0x55 then 0xA3 at 115200 with ack held high -> uart_dat_o=0x55 then 0xA3, one valid cycle each, no error pulses.
- Send 0x3C with the consumer not acking; 20 cycles after valid, pulse ack -> dat stays 0x3C until ack, valid drops the next cycle.
- Send 0x11 and 0x22 back-to-back with no ack -> dat=0x11, exactly one overrun pulse, then ack -> valid=0.
- Send 0x81 with the stop bit forced low, then hold the line low 3 bit times, then idle and send 0x42 -> one frame_err, no valid for 0x81, then dat=0x42.
- Send a 4-clock low glitch on idle rx -> no valid, no error; FSM returns to IDLE within 1 bit time.
- Assert sys_rst_i mid-data-bit 4 of a frame, release, then send 0x7E -> outputs 0 during reset, no partial byte delivered, then dat=0x7E.
- Baud tolerance: send 0xC5 at BAUD ±3% -> received 0xC5 correctly in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, sample points and default line settings
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  localparam int OVERSAMPLE = 16;

  // Three centre samples of every bit are majority-voted
  localparam logic [3:0] SAMPLE_A  = 4'd7;
  localparam logic [3:0] SAMPLE_B  = 4'd8;
  localparam logic [3:0] SAMPLE_C  = 4'd9;
  localparam logic [3:0] SCNT_LAST = 4'd15;

  localparam int DEFAULT_CLK_HZ = 150_000_000;
  localparam int DEFAULT_BAUD   = 115_200;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional accumulator tick generator
module uart_baud_gen #(
  parameter int CLK_HZ  = 150_000_000,
  parameter int RATE_HZ = 1_843_200,
  parameter int ACC_W   = 29
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [ACC_W:0] INC   = (ACC_W+1)'(RATE_HZ);
  localparam logic [ACC_W:0] LIMIT = (ACC_W+1)'(CLK_HZ);

  logic [ACC_W-1:0] r_acc;
  logic             r_tick;
  logic [ACC_W:0]   w_sum;

  // One extra bit so the sum can never wrap before the compare
  assign w_sum  = {1'b0, r_acc} + INC;
  assign tick_o = r_tick;

  // Free-running accumulator; average tick rate is exactly RATE_HZ
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_sum >= LIMIT) begin
      r_acc  <= ACC_W'(w_sum - LIMIT);
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling and holding register
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD,
  parameter int ACC_W  = 29
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_ack_i,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o
);

  logic        r_sync1;
  logic        r_sync2;
  logic        w_rxs;
  logic        w_tick;
  logic        w_vote;

  uart_state_e r_state;
  uart_state_e w_state_nxt;
  logic [3:0]  r_scnt;
  logic [3:0]  w_scnt_nxt;
  logic [2:0]  r_bidx;
  logic [2:0]  w_bidx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_s7;
  logic        w_s7_nxt;
  logic        r_s8;
  logic        w_s8_nxt;
  logic        r_deliver;
  logic        w_deliver_nxt;
  logic        r_ferr;
  logic        w_ferr_nxt;

  logic [7:0]  r_dat;
  logic        r_valid;
  logic        r_ovr;

  uart_baud_gen #(
    .CLK_HZ (CLK_HZ),
    .RATE_HZ(OVERSAMPLE * BAUD),
    .ACC_W  (ACC_W)
  ) u_baud_gen (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .tick_o(w_tick)
  );

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs  = r_sync2;
  assign w_vote = majority3(r_s7, r_s8, w_rxs);

  // Frame state register and per-frame datapath
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state   <= IDLE;
      r_scnt    <= '0;
      r_bidx    <= '0;
      r_shift   <= '0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
      r_deliver <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_scnt    <= w_scnt_nxt;
      r_bidx    <= w_bidx_nxt;
      r_shift   <= w_shift_nxt;
      r_s7      <= w_s7_nxt;
      r_s8      <= w_s8_nxt;
      r_deliver <= w_deliver_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  // Next-state decode; everything moves only on an oversample tick
  always_comb begin
    w_state_nxt   = r_state;
    w_scnt_nxt    = r_scnt;
    w_bidx_nxt    = r_bidx;
    w_shift_nxt   = r_shift;
    w_s7_nxt      = r_s7;
    w_s8_nxt      = r_s8;
    w_deliver_nxt = 1'b0;
    w_ferr_nxt    = 1'b0;

    if (w_tick) begin
      if (r_scnt == SAMPLE_A) w_s7_nxt = w_rxs;
      if (r_scnt == SAMPLE_B) w_s8_nxt = w_rxs;

      case (r_state)
        IDLE: begin
          // The detecting tick is sample 0 of the start bit
          w_scnt_nxt = '0;
          if (!w_rxs) begin
            w_state_nxt = START;
            w_scnt_nxt  = 4'd1;
          end
        end

        START: begin
          w_scnt_nxt = r_scnt + 4'd1;
          if (r_scnt == SAMPLE_C && w_vote) begin
            w_state_nxt = IDLE;
            w_scnt_nxt  = '0;
          end else if (r_scnt == SCNT_LAST) begin
            w_state_nxt = DATA;
            w_bidx_nxt  = '0;
          end
        end

        DATA: begin
          w_scnt_nxt = r_scnt + 4'd1;
          if (r_scnt == SAMPLE_C) w_shift_nxt = {w_vote, r_shift[7:1]};
          if (r_scnt == SCNT_LAST) begin
            if (r_bidx == 3'd7) w_state_nxt = STOP;
            else                w_bidx_nxt  = r_bidx + 3'd1;
          end
        end

        STOP: begin
          w_scnt_nxt = r_scnt + 4'd1;
          // Leaving at sample 9 lets a new start edge be seen from sample 10
          if (r_scnt == SAMPLE_C) begin
            w_scnt_nxt = '0;
            if (w_vote) begin
              w_deliver_nxt = 1'b1;
              w_state_nxt   = IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = BREAK;
            end
          end
        end

        BREAK: begin
          // A held-low line reports one frame error, then waits for idle
          w_scnt_nxt = '0;
          if (w_rxs) w_state_nxt = IDLE;
        end

        default: begin
          w_state_nxt = IDLE;
          w_scnt_nxt  = '0;
        end
      endcase
    end
  end

  // Single-entry holding register with ack handshake and overrun detection
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_deliver) begin
        if (!r_valid || uart_ack_i) begin
          r_dat   <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && uart_ack_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign uart_dat_o       = r_dat;
  assign uart_valid_o     = r_valid;
  assign uart_frame_err_o = r_ferr;
  assign uart_overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int  CLK_HZ   = 15_000_000;
  localparam int  BAUD     = 115_200;
  localparam real CLK_HALF = 1.0e9 / CLK_HZ / 2.0;
  localparam real BIT_NS   = 1.0e9 / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always #(CLK_HALF) clk = ~clk;

  uart_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .ACC_W (29)
  ) dut (
    .sys_clk_i       (clk),
    .sys_rst_i       (rst),
    .uart_rx         (rx),
    .uart_dat_o      (dat),
    .uart_valid_o    (valid),
    .uart_ack_i      (ack),
    .uart_frame_err_o(ferr),
    .uart_overrun_o  (ovr)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every new byte presentation
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (valid) valid_cycles++;
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (ferr || ovr) begin
        total++;
        if (ferr && ovr) begin
          bad++;
          $display("FAIL pulse_overlap: frame_err=%0b overrun=%0b expected not both", ferr, ovr);
        end
      end
      if (valid && !prev_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected no delivery", dat);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dat !== e) begin
            bad++;
            $display("FAIL rx_byte: got 0x%0h expected 0x%0h", dat, e);
          end
        end
      end
      prev_valid = valid;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input real n);
    rx = 1'b1;
    #(n * BIT_NS);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(valid), 1);
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int vc;
    // Reset state
    repeat (4) @(negedge clk);
    check("reset_dat", dat, 0);
    check("reset_valid", valid, 0);
    check("reset_ferr", ferr, 0);
    check("reset_ovr", ovr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle_bits(2.0);

    // Two bytes with ack held high
    ack = 1'b1;
    valid_cycles = 0; ferr_cnt = 0; ovr_cnt = 0;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, BIT_NS);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1, BIT_NS);
    idle_bits(1.0);
    wait_drain("drain_55_a3");
    check("valid_cycles_55_a3", valid_cycles, 2);
    check("ferr_55_a3", ferr_cnt, 0);
    check("ovr_55_a3", ovr_cnt, 0);

    // Held byte until the consumer acks
    ack = 1'b0;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, BIT_NS);
    wait_valid("valid_3c");
    repeat (20) @(negedge clk);
    check("hold_dat_3c", dat, 8'h3C);
    check("hold_valid_3c", valid, 1);
    pulse_ack();
    check("ack_valid_3c", valid, 0);
    check("ack_dat_3c", dat, 8'h3C);

    // Back-to-back without ack: second byte overruns
    ovr_cnt = 0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, BIT_NS);
    send_byte(8'h22, 1'b1, BIT_NS);
    idle_bits(1.0);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_dat_kept", dat, 8'h11);
    check("ovr_valid", valid, 1);
    pulse_ack();
    check("ovr_ack_valid", valid, 0);
    wait_drain("drain_11");

    // Framing error followed by break, then a good byte
    ack = 1'b1;
    ferr_cnt = 0; ovr_cnt = 0;
    send_byte(8'h81, 1'b0, BIT_NS);
    rx = 1'b0;
    #(3.0 * BIT_NS);
    idle_bits(2.0);
    check("ferr_break_count", ferr_cnt, 1);
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1, BIT_NS);
    idle_bits(1.0);
    wait_drain("drain_42");
    check("ferr_after_42", ferr_cnt, 1);
    check("ovr_after_42", ovr_cnt, 0);

    // Short glitch on the idle line is rejected
    ferr_cnt = 0;
    vc = valid_cycles;
    @(posedge clk);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    idle_bits(1.0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_no_valid", valid_cycles - vc, 0);
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1, BIT_NS);
    idle_bits(1.0);
    wait_drain("drain_96");

    // Reset during data bit 4 of 0xF0, then a clean 0x7E
    vc = valid_cycles;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) #(BIT_NS);
    rx = 1'b1;
    #(0.5 * BIT_NS);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_dat", dat, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ferr", ferr, 0);
    check("midrst_ovr", ovr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle_bits(5.0);
    check("midrst_no_partial", valid_cycles - vc, 0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, BIT_NS);
    idle_bits(1.0);
    wait_drain("drain_7e");

    // Baud tolerance, 3% fast then 3% slow
    exp_q.push_back(8'hC5);
    send_byte(8'hC5, 1'b1, BIT_NS / 1.03);
    idle_bits(1.0);
    wait_drain("drain_c5_fast");
    exp_q.push_back(8'hC5);
    send_byte(8'hC5, 1'b1, BIT_NS * 1.03);
    idle_bits(1.0);
    wait_drain("drain_c5_slow");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
